// File: rtl/regfile_pkg.sv
// Shared constants, word type and port-count helper for the multi-port register file.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NREAD = 2;

  typedef logic [RF_WIDTH-1:0] rf_word_t;

  // Read-port count is limited to 1..4; out-of-range requests are clamped.
  function automatic int rf_clamp_nread(input int n);
    if (n < 1) return 1;
    if (n > 4) return 4;
    return n;
  endfunction

endpackage

// File: rtl/regfile_mp_rf_read_port.sv
// One registered read port: DEPTH-way select, out-of-range zero, write bypass.
// REGFILE_ZERO_REG_EN: address 0 always reads 0 and is never bypassed.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        re,
  input  logic [AW-1:0]               raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0] entries,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        rvalid
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic             in_range_p0;
  logic [WIDTH-1:0] sel_p0;
  logic [WIDTH-1:0] rdata_p1;
  logic             vld_p1;

  always_comb begin
    in_range_p0 = ({1'b0, raddr} < DEPTH_L);
    sel_p0      = '0;
    if (in_range_p0) begin
      if (we && (waddr == raddr))
        sel_p0 = wdata;
      else
        sel_p0 = entries[raddr];
    end
`ifdef REGFILE_ZERO_REG_EN
    if (raddr == '0)
      sel_p0 = '0;
`endif
  end

  // p0 -> p1: output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= re;
      if (re)
        rdata_p1 <= sel_p0;
    end
  end

  assign rdata  = rdata_p1;
  assign rvalid = vld_p1;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one synchronous write port, NREAD registered read ports.
// REGFILE_ZERO_REG_EN: entry 0 is hardwired to zero and writes to it are dropped.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  parameter  int NREAD = RF_NREAD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rvalid
);

  localparam int          NR_EFF  = rf_clamp_nread(NREAD);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_ok;

  always_comb begin
    wr_ok = we && ({1'b0, waddr} < DEPTH_L);
`ifdef REGFILE_ZERO_REG_EN
    if (waddr == '0)
      wr_ok = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      mem <= '0;
    else if (wr_ok)
      mem[waddr] <= wdata;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    if (p < NR_EFF) begin : g_on
      rf_read_port #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
      ) u_port (
        .clk    (clk),
        .reset_n(reset_n),
        .re     (re[p]),
        .raddr  (raddr[p*AW +: AW]),
        .entries(mem),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata[p*WIDTH +: WIDTH]),
        .rvalid (rvalid[p])
      );
    end else begin : g_off
      assign rdata[p*WIDTH +: WIDTH] = '0;
      assign rvalid[p]               = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (WIDTH=32, DEPTH=20, NREAD=2).
module tb_regfile_mp;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rvalid;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .DEPTH(20), .NREAD(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  typedef struct {
    string       nm;
    logic [1:0]  vm;
    logic [1:0]  ve;
    logic [1:0]  dm;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    logic [31:0] got, want;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int p = 0; p < 2; p++) begin
        if (e.vm[p]) begin
          tests++;
          if (rvalid[p] !== e.ve[p]) begin
            fails++;
            $display("FAIL %s rvalid[%0d] got %b expected %b", e.nm, p, rvalid[p], e.ve[p]);
          end
        end
        if (e.dm[p]) begin
          tests++;
          got  = rdata[p*32 +: 32];
          want = (p == 0) ? e.d0 : e.d1;
          if (got !== want) begin
            fails++;
            $display("FAIL %s rdata%0d got %h expected %h", e.nm, p, got, want);
          end
        end
      end
    end
  end

  task automatic cyc(input logic rn, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                     input string nm, input logic [1:0] vm, input logic [1:0] ve,
                     input logic [1:0] dm, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    reset_n = rn; we = w; waddr = wa; wdata = wd; re = r; raddr = {a1, a0};
    @(posedge clk);
    e.nm = nm; e.vm = vm; e.ve = ve; e.dm = dm; e.d0 = d0; e.d1 = d1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] z0, zb;
    z0 = ZR ? 32'h0 : 32'hFFFF_FFFF;
    zb = ZR ? 32'h0 : 32'h1357_2468;

    // Reset held 2 cycles with a write and reads presented: all ignored.
    cyc(0, 1, 5'd5, 32'hDEAD_BEEF, 2'b11, 5'd5, 5'd5, "rst0", 2'b11, 2'b00, 2'b11, 0, 0);
    cyc(0, 1, 5'd5, 32'hDEAD_BEEF, 2'b11, 5'd5, 5'd5, "rst1", 2'b11, 2'b00, 2'b11, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, "rd5_after_rst", 2'b11, 2'b01, 2'b01, 0, 0);

    // Write then read on both ports.
    cyc(1, 1, 5'd7, 32'h1234_5678, 2'b00, 5'd0, 5'd0, "wr7", 2'b11, 2'b00, 2'b01, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd3, "rd7_rd3", 2'b11, 2'b11, 2'b11, 32'h1234_5678, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b00, 5'd7, 5'd3, "hold", 2'b11, 2'b00, 2'b11, 32'h1234_5678, 0);

    // Bypass: new value forwarded, then visible through the array.
    cyc(1, 1, 5'd9, 32'hAAAA_AAAA, 2'b00, 5'd0, 5'd0, "wr9a", 2'b11, 2'b00, 2'b11, 32'h1234_5678, 0);
    cyc(1, 1, 5'd9, 32'h5555_5555, 2'b10, 5'd0, 5'd9, "bypass9", 2'b11, 2'b10, 2'b11,
        32'h1234_5678, 32'h5555_5555);
    cyc(1, 0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, "rd9_array", 2'b11, 2'b01, 2'b11,
        32'h5555_5555, 32'h5555_5555);

    // Address 0: hardwired zero or ordinary entry depending on build.
    cyc(1, 1, 5'd0, 32'hFFFF_FFFF, 2'b00, 5'd0, 5'd0, "wr0", 2'b11, 2'b00, 2'b00, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, "rd0", 2'b11, 2'b01, 2'b01, z0, 0);
    cyc(1, 1, 5'd0, 32'h1357_2468, 2'b11, 5'd0, 5'd0, "bypass0", 2'b11, 2'b11, 2'b11, zb, zb);

    // Out-of-range write dropped; out-of-range read returns 0; aliased entry untouched.
    cyc(1, 1, 5'd25, 32'h0000_00AB, 2'b00, 5'd0, 5'd0, "wr25", 2'b11, 2'b00, 2'b00, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b11, 5'd25, 5'd5, "rd25_rd5", 2'b11, 2'b11, 2'b11, 0, 0);
    cyc(1, 1, 5'd25, 32'h0000_00CD, 2'b01, 5'd25, 5'd0, "bypass25", 2'b11, 2'b01, 2'b01, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd9, "rd7_rd9", 2'b11, 2'b11, 2'b11,
        32'h1234_5678, 32'h5555_5555);

    // Reset during an active read, with a simultaneous write that must be lost.
    cyc(1, 0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, "rd7_pre", 2'b11, 2'b01, 2'b01, 32'h1234_5678, 0);
    cyc(0, 1, 5'd7, 32'h0000_0001, 2'b11, 5'd7, 5'd9, "midrst", 2'b11, 2'b00, 2'b11, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd9, "rd_post_rst", 2'b11, 2'b11, 2'b11, 0, 0);
    cyc(1, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, "idle", 2'b11, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
